// File: rtl/axi4_test_pkg.sv
// Shared definitions for the LPDDR4 AXI4 test path: lane count, checker state
// encoding and the pattern-increment rule common to the write and check stages.
package axi4_test_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ARMED = ST_ARMED,
    CHECK = ST_CHECK
  } chk_state_e;

  localparam int unsigned ERR_CNT_W  = 16;
  localparam int unsigned BEAT_CNT_W = 32;

  function automatic int unsigned calc_lanes(input int unsigned bus_w,
                                             input int unsigned lane_w);
    return bus_w / lane_w;
  endfunction

  // Lane-width modular add: the single definition of how the pattern advances.
  function automatic logic [31:0] pat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned lane_w);
    logic [63:0] mask;
    mask = (64'd1 << lane_w) - 64'd1;
    return 32'((64'(a) + 64'(b)) & mask);
  endfunction

endpackage

// File: rtl/axi4_read_data_checker_if.sv
// Bus bundle between the AXI4 read sequence and the read data checker.
// i_err_inject exists only when AXI4_CHECKER_ERRINJ_EN is defined.
interface axi4_read_data_checker_if #(
  parameter int unsigned pAxi4BusWidth = 512,
  parameter int unsigned pDataBitWidth = 16
);
  import axi4_test_pkg::*;

  localparam int unsigned LANES = calc_lanes(pAxi4BusWidth, pDataBitWidth);

  logic [pAxi4BusWidth-1:0] i_rdata;
  logic                     i_rvalid;
  logic                     i_wdone;
  logic                     i_clear;
`ifdef AXI4_CHECKER_ERRINJ_EN
  logic                     i_err_inject;
`endif
  logic                     o_fail;
  logic [ERR_CNT_W-1:0]     o_err_cnt;
  logic [BEAT_CNT_W-1:0]    o_beat_cnt;
  logic                     o_burst_done;
  logic [LANES-1:0]         o_first_err_mask;
  logic                     o_busy;

  modport master (
    output i_rdata, i_rvalid, i_wdone, i_clear,
`ifdef AXI4_CHECKER_ERRINJ_EN
    output i_err_inject,
`endif
    input  o_fail, o_err_cnt, o_beat_cnt, o_burst_done, o_first_err_mask, o_busy
  );

  modport slave (
    input  i_rdata, i_rvalid, i_wdone, i_clear,
`ifdef AXI4_CHECKER_ERRINJ_EN
    input  i_err_inject,
`endif
    output o_fail, o_err_cnt, o_beat_cnt, o_burst_done, o_first_err_mask, o_busy
  );

endinterface

// File: rtl/axi4_pattern_gen.sv
// Expected-word generator: base register plus per-lane adders. Lane x of the
// current beat is base + x; the base advances by LANES per accepted beat.
module axi4_pattern_gen
  import axi4_test_pkg::*;
#(
  parameter int unsigned pDataBitWidth = 16,
  parameter int unsigned pLanes        = 32,
  parameter int unsigned pPatSeed      = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cke,
  input  logic                              clr,
  output logic [pLanes*pDataBitWidth-1:0]   exp_word_c
);

  localparam int unsigned W = pDataBitWidth;
  localparam logic [W-1:0] SEED_W = W'(pPatSeed);

  logic [W-1:0] base_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= SEED_W;
    end else if (clr) begin
      base_q <= SEED_W;
    end else if (cke) begin
      base_q <= W'(pat_add(32'(base_q), 32'(pLanes), W));
    end
  end

  always_comb begin
    exp_word_c = '0;
    for (int x = 0; x < int'(pLanes); x++) begin
      exp_word_c[x*W +: W] = W'(pat_add(32'(base_q), 32'(x), W));
    end
  end

endmodule

// File: rtl/axi4_read_data_checker.sv
// Read data checker: regenerates the incrementing lane pattern and compares
// every accepted beat in a 3-stage pipeline. Optional AXI4_CHECKER_ERRINJ_EN.
module axi4_read_data_checker
  import axi4_test_pkg::*;
#(
  parameter int unsigned pAxi4BusWidth = 512,
  parameter int unsigned pDataBitWidth = 16,
  parameter int unsigned pDdrBurstSize = 16,
  parameter int unsigned pPatSeed      = 0
) (
  input logic                     iCLK,
  input logic                     iRSTn,
  axi4_read_data_checker_if.slave bus
);

  localparam int unsigned LANES = calc_lanes(pAxi4BusWidth, pDataBitWidth);
  localparam int unsigned W     = pDataBitWidth;
  localparam int unsigned BW    = pAxi4BusWidth;
  localparam int unsigned IDX_W = (pDdrBurstSize > 1) ? $clog2(pDdrBurstSize) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(pDdrBurstSize - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  chk_state_e              state_q, state_d;
  logic [IDX_W-1:0]        beat_idx_q;
  logic                    accept_c;
  logic                    last_c;
  logic                    busy_q;
  logic [BEAT_CNT_W-1:0]   beat_cnt_q;
  logic [BW-1:0]           exp_word_c;
  logic                    inj_c;

  logic                    s1_valid_q, s1_last_q;
  logic [BW-1:0]           s1_data_q, s1_exp_q;
  logic [LANES-1:0]        mask_c;
  logic                    s2_valid_q, s2_last_q;
  logic [LANES-1:0]        s2_mask_q;
  logic                    fail_q;
  logic [ERR_CNT_W-1:0]    err_cnt_q;
  logic [LANES-1:0]        first_mask_q;
  logic                    burst_done_q;

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and beat acceptance; clear overrides everything, IDLE ignores beats.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    last_c   = 1'b0;
    if (bus.i_clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_wdone) state_d = ARMED;
        end
        ARMED: begin
          if (bus.i_rvalid) begin
            accept_c = 1'b1;
            state_d  = (beat_idx_q == LAST_IDX) ? ARMED : CHECK;
          end
        end
        CHECK: begin
          if (bus.i_rvalid) begin
            accept_c = 1'b1;
            if (beat_idx_q == LAST_IDX) state_d = ARMED;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    last_c = accept_c && (beat_idx_q == LAST_IDX);
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      beat_idx_q <= '0;
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      busy_q <= (state_d != IDLE);
      if (bus.i_clear) begin
        beat_idx_q <= '0;
        beat_cnt_q <= '0;
      end else if (accept_c) begin
        beat_idx_q <= last_c ? '0 : beat_idx_q + IDX_W'(1);
        beat_cnt_q <= beat_cnt_q + BEAT_CNT_W'(1);
      end
    end
  end

  axi4_pattern_gen #(
    .pDataBitWidth (pDataBitWidth),
    .pLanes        (LANES),
    .pPatSeed      (pPatSeed)
  ) u_pattern_gen (
    .clk        (iCLK),
    .rst_n      (iRSTn),
    .cke        (accept_c),
    .clr        (bus.i_clear),
    .exp_word_c (exp_word_c)
  );

`ifdef AXI4_CHECKER_ERRINJ_EN
  // One-shot: a pulse poisons lane 0 bit 0 of the next accepted beat's expectation.
  logic inj_q;
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      inj_q <= 1'b0;
    end else if (bus.i_clear) begin
      inj_q <= 1'b0;
    end else if (accept_c) begin
      inj_q <= bus.i_err_inject;
    end else if (bus.i_err_inject) begin
      inj_q <= 1'b1;
    end
  end
  assign inj_c = inj_q;
`else
  assign inj_c = 1'b0;
`endif

  // Stage 1: capture beat and expected word.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_data_q  <= '0;
      s1_exp_q   <= '0;
    end else begin
      s1_valid_q <= accept_c;
      s1_last_q  <= last_c;
      if (accept_c) begin
        s1_data_q <= bus.i_rdata;
        s1_exp_q  <= exp_word_c ^ BW'(inj_c);
      end
    end
  end

  always_comb begin
    mask_c = '0;
    for (int x = 0; x < int'(LANES); x++) begin
      mask_c[x] = (s1_data_q[x*W +: W] != s1_exp_q[x*W +: W]);
    end
  end

  // Stage 2: per-lane mismatch mask.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_mask_q  <= '0;
    end else begin
      s2_valid_q <= s1_valid_q && !bus.i_clear;
      s2_last_q  <= s1_last_q;
      s2_mask_q  <= mask_c;
    end
  end

  // Stage 3: reduce mask and update sticky status.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      fail_q       <= 1'b0;
      err_cnt_q    <= '0;
      first_mask_q <= '0;
      burst_done_q <= 1'b0;
    end else if (bus.i_clear) begin
      fail_q       <= 1'b0;
      err_cnt_q    <= '0;
      first_mask_q <= '0;
      burst_done_q <= 1'b0;
    end else begin
      burst_done_q <= s2_valid_q && s2_last_q;
      if (s2_valid_q && (|s2_mask_q)) begin
        fail_q <= 1'b1;
        if (err_cnt_q != ERR_MAX) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        if (!fail_q) first_mask_q <= s2_mask_q;
      end
    end
  end

  assign bus.o_fail           = fail_q;
  assign bus.o_err_cnt        = err_cnt_q;
  assign bus.o_beat_cnt       = beat_cnt_q;
  assign bus.o_burst_done     = burst_done_q;
  assign bus.o_first_err_mask = first_mask_q;
  assign bus.o_busy           = busy_q;

endmodule
